xy_serializer: RTL and testbench

XY_SERIALIZER -- requirements
Module: xy_serializer

---
 rtl/nco_io_pkg.sv | 18 +
 rtl/xy_serializer.sv | 104 ++++++++++
 tb/tb_xy_serializer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nco_io_pkg.sv
// Shared sizing, FSM encoding and frame timing for the X/Y chunk serializer.
// Frame cycles are counted from the capture edge: cycle 1 is Rdy, chunks start at cycle 2, sign cycle is 8.
package nco_io_pkg;

  localparam int DW         = 12;
  localparam int CW         = 2;
  localparam int NCH        = DW / CW;
  localparam int CHUNK0_CYC = 2;
  localparam int SIGN_CYC   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_SIGN  = 2'd3
  } state_t;

endpackage

// File: rtl/xy_serializer.sv
// Serializes a captured X/Y sample as NCH chunks (LSB first) after a one-cycle Rdy strobe; 8-cycle frame.
// Backpressure: in_ready is high only in IDLE and SIGN, so upstream holds data until the frame is done.
module xy_serializer
  import nco_io_pkg::*;
#(
  parameter int DW  = nco_io_pkg::DW,
  parameter int CW  = nco_io_pkg::CW,
  parameter int NCH = nco_io_pkg::DW / nco_io_pkg::CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] Xdata,
  input  logic [DW-1:0] Ydata,
  input  logic          ISdata,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          Rdy,
  output logic [CW-1:0] Xout,
  output logic [CW-1:0] Yout,
  output logic          ISout,
  input  logic          Vld,
  output logic          frame_err
);

  localparam int CNTW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t          r_state;
  logic [CNTW-1:0] r_cnt;
  logic [DW-1:0]   r_xsh;
  logic [DW-1:0]   r_ysh;
  logic            r_is;
  logic            w_cap;

  assign w_cap = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_xsh     <= '0;
      r_ysh     <= '0;
      r_is      <= 1'b0;
      in_ready  <= 1'b1;
      Rdy       <= 1'b0;
      Xout      <= '0;
      Yout      <= '0;
      ISout     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      Rdy <= 1'b0;
      if (w_cap) begin
        r_xsh <= Xdata;
        r_ysh <= Ydata;
        r_is  <= ISdata;
      end
      // Vld belongs exactly to the SIGN cycle; anything else is a framing error
      if (Vld != (r_state == ST_SIGN)) begin
        frame_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_cap) begin
            r_state  <= ST_REQ;
            Rdy      <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        ST_REQ: begin
          r_state <= ST_SHIFT;
          r_cnt   <= '0;
          Xout    <= r_xsh[CW-1:0];
          Yout    <= r_ysh[CW-1:0];
          r_xsh   <= r_xsh >> CW;
          r_ysh   <= r_ysh >> CW;
          ISout   <= r_is;
        end
        ST_SHIFT: begin
          if (r_cnt == CNTW'(NCH - 1)) begin
            r_state  <= ST_SIGN;
            in_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNTW'(1);
            Xout  <= r_xsh[CW-1:0];
            Yout  <= r_ysh[CW-1:0];
            r_xsh <= r_xsh >> CW;
            r_ysh <= r_ysh >> CW;
          end
        end
        ST_SIGN: begin
          // A capture here starts the next frame back-to-back
          if (w_cap) begin
            r_state  <= ST_REQ;
            Rdy      <= 1'b1;
            in_ready <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xy_serializer.sv
// Directed bench for xy_serializer with an inline output-terminal model that reassembles chunks and returns Vld.
module tb_xy_serializer;
  import nco_io_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] Xdata;
  logic [DW-1:0] Ydata;
  logic          ISdata;
  logic          in_valid;
  logic          in_ready;
  logic          Rdy;
  logic [CW-1:0] Xout;
  logic [CW-1:0] Yout;
  logic          ISout;
  logic          Vld = 1'b0;
  logic          frame_err;

  always #5 clk = ~clk;

  xy_serializer #(.DW(DW), .CW(CW), .NCH(NCH)) dut (
    .clk      (clk),
    .rst      (rst),
    .Xdata    (Xdata),
    .Ydata    (Ydata),
    .ISdata   (ISdata),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Rdy      (Rdy),
    .Xout     (Xout),
    .Yout     (Yout),
    .ISout    (ISout),
    .Vld      (Vld),
    .frame_err(frame_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one sample for a single edge in IDLE; returns in cycle 1 of the frame.
  task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic is);
    Xdata    = x;
    Ydata    = y;
    ISdata   = is;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Output terminal: tracks frame cycle from Rdy, collects chunks mid-cycle, drives Vld in the sign cycle.
  logic          term_en = 1'b1;
  int            t_cyc = 0;
  int            t_frames = 0;
  logic [DW-1:0] t_x = '0;
  logic [DW-1:0] t_y = '0;
  logic [DW-1:0] t_done_x = '0;
  logic [DW-1:0] t_done_y = '0;
  logic          t_done_is = 1'b0;

  always @(negedge clk) begin
    if (rst) t_cyc = 0;
    else if (Rdy) t_cyc = 1;
    else if (t_cyc != 0 && t_cyc < SIGN_CYC) t_cyc = t_cyc + 1;
    else t_cyc = 0;
    if (t_cyc >= CHUNK0_CYC && t_cyc < SIGN_CYC) begin
      t_x[CW*(t_cyc-CHUNK0_CYC) +: CW] = Xout;
      t_y[CW*(t_cyc-CHUNK0_CYC) +: CW] = Yout;
    end
    if (t_cyc == SIGN_CYC) begin
      t_done_x  = t_x;
      t_done_y  = t_y;
      t_done_is = ISout;
      t_frames  = t_frames + 1;
    end
    Vld = term_en && (t_cyc == SIGN_CYC);
  end

  logic [CW-1:0] xe [6] = '{2'd0, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2};
  logic [CW-1:0] ye [6] = '{2'd3, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};
  logic [DW-1:0] sx [3] = '{12'h5A5, 12'hFFF, 12'h000};
  logic [DW-1:0] sy [3] = '{12'h3C3, 12'h001, 12'h800};

  initial begin
    int f0;
    int rdy_cnt;
    rst      = 1'b1;
    in_valid = 1'b0;
    Xdata    = '0;
    Ydata    = '0;
    ISdata   = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_rdy", Rdy, 0);
    check("rst_xout", Xout, 0);
    check("rst_yout", Yout, 0);
    check("rst_isout", ISout, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_frame_err", frame_err, 0);
    rst = 1'b0;

    // Single frame X=0xABC Y=0x123, captured at the first edge after reset
    send(12'hABC, 12'h123, 1'b0);
    check("t1_rdy_c1", Rdy, 1);
    check("t1_in_ready_c1", in_ready, 0);
    for (int k = 0; k < NCH; k++) begin
      tick();
      check($sformatf("t1_x_c%0d", k + 2), Xout, xe[k]);
      check($sformatf("t1_y_c%0d", k + 2), Yout, ye[k]);
      check($sformatf("t1_rdy_c%0d", k + 2), Rdy, 0);
      check($sformatf("t1_in_ready_c%0d", k + 2), in_ready, 0);
    end
    tick();
    check("t1_in_ready_c8", in_ready, 1);
    check("t1_isout_c8", ISout, 0);
    check("t1_hold_x_c8", Xout, 2);
    tick();
    check("t1_in_ready_c9", in_ready, 1);
    check("t1_frame_err", frame_err, 0);

    // Three samples with in_valid held: Rdy every 8 cycles, in_ready only in SIGN
    f0       = t_frames;
    Xdata    = sx[0];
    Ydata    = sy[0];
    ISdata   = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3 * SIGN_CYC; i++) begin
      tick();
      check($sformatf("t2_rdy_e%0d", i), Rdy, (i % 8 == 0));
      check($sformatf("t2_in_ready_e%0d", i), in_ready, (i % 8 == 7));
      if (i % 8 == 0) begin
        if (i >= 8) begin
          check($sformatf("t2_term_x_f%0d", i / 8 - 1), t_done_x, sx[i/8-1]);
          check($sformatf("t2_term_y_f%0d", i / 8 - 1), t_done_y, sy[i/8-1]);
        end
        if (i / 8 < 2) begin
          Xdata = sx[i/8+1];
          Ydata = sy[i/8+1];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    tick();
    check("t2_idle_in_ready", in_ready, 1);
    check("t2_idle_rdy", Rdy, 0);
    check("t2_term_x_f2", t_done_x, sx[2]);
    check("t2_frames", t_frames - f0, 3);
    check("t2_frame_err", frame_err, 0);

    // Terminal round trip with IS=1, X=0x001
    send(12'h001, 12'hFFE, 1'b1);
    for (int k = 0; k < SIGN_CYC; k++) tick();
    check("t3_term_x", t_done_x, 12'h001);
    check("t3_term_y", t_done_y, 12'hFFE);
    check("t3_term_is", t_done_is, 1);
    check("t3_isout_c9", ISout, 1);
    check("t3_frame_err", frame_err, 0);

    // Vld tied low: error after cycle 8, sticky until reset
    term_en = 1'b0;
    send(12'h555, 12'hAAA, 1'b0);
    for (int k = 0; k < SIGN_CYC - 1; k++) tick();
    check("t4_err_c8", frame_err, 0);
    tick();
    check("t4_err_c9", frame_err, 1);
    for (int k = 0; k < 10; k++) tick();
    check("t4_err_sticky", frame_err, 1);
    rst = 1'b1;
    #1;
    check("t4_err_cleared", frame_err, 0);
    tick();
    rst     = 1'b0;
    term_en = 1'b1;

    // Reset in cycle 4 aborts the frame
    send(12'hFFF, 12'hFFF, 1'b1);
    tick();
    tick();
    tick();
    check("t5_x_c4", Xout, 3);
    rst = 1'b1;
    #1;
    check("t5_x_rst", Xout, 0);
    check("t5_y_rst", Yout, 0);
    check("t5_rdy_rst", Rdy, 0);
    check("t5_isout_rst", ISout, 0);
    check("t5_in_ready_rst", in_ready, 1);
    tick();
    rst     = 1'b0;
    rdy_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (Rdy) rdy_cnt++;
    end
    check("t5_no_rdy", rdy_cnt, 0);
    check("t5_x_idle", Xout, 0);
    check("t5_frame_err", frame_err, 0);

    // in_valid raised in cycle 3: no capture until in_ready in cycle 8
    send(12'h9C6, 12'h639, 1'b0);
    tick();
    tick();
    Xdata    = 12'h2D7;
    Ydata    = 12'hE18;
    ISdata   = 1'b1;
    in_valid = 1'b1;
    for (int j = 3; j < SIGN_CYC; j++) begin
      tick();
      check($sformatf("t6_rdy_c%0d", j + 1), Rdy, 0);
      check($sformatf("t6_in_ready_c%0d", j + 1), in_ready, (j == SIGN_CYC - 1));
    end
    tick();
    in_valid = 1'b0;
    check("t6_rdy_e8", Rdy, 1);
    check("t6_old_x", t_done_x, 12'h9C6);
    check("t6_old_y", t_done_y, 12'h639);
    for (int k = 0; k < SIGN_CYC; k++) tick();
    check("t6_new_x", t_done_x, 12'h2D7);
    check("t6_new_y", t_done_y, 12'hE18);
    check("t6_new_isout", ISout, 1);
    check("t6_frame_err", frame_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
